unstrip_lane_sched: RTL and testbench

//  Controller/scheduler that merges the two 32-bit lanes feeding the byte unstriping datapath into one ordered stream.

---
 rtl/unstrip_lane_sched.sv | 165 ++++++++++++++++
 tb/tb_unstrip_lane_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/unstrip_lane_sched.sv
// Merges two skewed 32-bit lanes into one round-robin ordered stream through
// per-lane deskew FIFOs, flagging lane loss or FIFO overflow with skew_err.
module unstrip_lane_sched #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int MAX_STALL = 8,
  parameter int IDLE_TO   = 4
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] lane_0,
  input  logic             valid_0,
  input  logic [WIDTH-1:0] lane_1,
  input  logic             valid_1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             next_lane,
  output logic             active,
  output logic             skew_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam int IW = $clog2(IDLE_TO + 1);

  localparam logic [CW-1:0] OCC_FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] STALL_LIM = SW'(MAX_STALL);
  localparam logic [IW-1:0] IDLE_LIM  = IW'(IDLE_TO);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_RUN   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] fifo_mem [2][DEPTH];
  logic [AW-1:0]    wr_ptr   [2];
  logic [AW-1:0]    rd_ptr   [2];
  logic [CW-1:0]    occ      [2];
  logic [WIDTH-1:0] lane_in  [2];

  logic [SW-1:0] stall_cnt, stall_d, stall_inc;
  logic [IW-1:0] idle_cnt, idle_d, idle_inc;

  logic [1:0] push, pop, accept, empty, full;
  logic       pop_any, ovf, idle_cond, flush;
  logic [WIDTH-1:0] head;

  // Per-lane FIFO status and the round-robin pop decision
  always_comb begin
    lane_in[0] = lane_0;
    lane_in[1] = lane_1;
    push       = {valid_1, valid_0} & {2{state != S_ERROR}};
    for (int i = 0; i < 2; i++) begin
      empty[i] = (occ[i] == '0);
      full[i]  = (occ[i] == OCC_FULL);
    end
    pop[0]    = (state == S_RUN) && !next_lane && !empty[0];
    pop[1]    = (state == S_RUN) &&  next_lane && !empty[1];
    pop_any   = |pop;
    // A full FIFO may only take a word when its head leaves on the same edge.
    accept    = push & (~full | pop);
    ovf       = |(push & full & ~pop);
    idle_cond = &empty && !valid_0 && !valid_1 && !next_lane;
    head      = next_lane ? fifo_mem[1][rd_ptr[1]] : fifo_mem[0][rd_ptr[0]];
    stall_inc = (stall_cnt == STALL_LIM) ? stall_cnt : stall_cnt + SW'(1);
    idle_inc  = (idle_cnt == IDLE_LIM) ? idle_cnt : idle_cnt + IW'(1);
  end

  // Next-state and counter logic; errors take priority over clean idle exit
  always_comb begin
    state_d = state;
    stall_d = stall_cnt;
    idle_d  = '0;
    flush   = 1'b0;
    unique case (state)
      S_IDLE: begin
        stall_d = '0;
        if (valid_0 || valid_1) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (!empty[0] && !empty[1]) begin
          state_d = S_RUN;
          stall_d = '0;
        end else begin
          stall_d = stall_inc;
          if (stall_inc == STALL_LIM) state_d = S_ERROR;
        end
        if (ovf) state_d = S_ERROR;
      end
      S_RUN: begin
        stall_d = pop_any ? '0 : stall_inc;
        idle_d  = idle_cond ? idle_inc : '0;
        if (ovf || (stall_d == STALL_LIM)) begin
          state_d = S_ERROR;
        end else if (idle_cond && (idle_d == IDLE_LIM)) begin
          state_d = S_IDLE;
          stall_d = '0;
          idle_d  = '0;
        end
      end
      S_ERROR: begin
        state_d = S_IDLE;
        stall_d = '0;
        flush   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, FIFO pointers and registered output stage
  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      state     <= S_IDLE;
      stall_cnt <= '0;
      idle_cnt  <= '0;
      next_lane <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        occ[i]    <= '0;
      end
    end else begin
      state     <= state_d;
      stall_cnt <= stall_d;
      idle_cnt  <= idle_d;
      for (int i = 0; i < 2; i++) begin
        if (flush) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          occ[i]    <= '0;
        end else begin
          if (accept[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
          if (pop[i])    rd_ptr[i] <= rd_ptr[i] + AW'(1);
          occ[i] <= occ[i] + CW'(accept[i]) - CW'(pop[i]);
        end
      end
      if (pop_any) begin
        data_out  <= head;
        valid_out <= 1'b1;
        next_lane <= ~next_lane;
      end else begin
        valid_out <= 1'b0;
      end
      if (flush) next_lane <= 1'b0;
    end
  end

  // FIFO storage carries data only, so it is never reset
  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) fifo_mem[i][wr_ptr[i]] <= lane_in[i];
    end
  end

  assign active   = (state == S_SYNC) || (state == S_RUN);
  assign skew_err = (state == S_ERROR);

endmodule

// File: tb/tb_unstrip_lane_sched.sv
// Directed and randomized stimulus for unstrip_lane_sched, compared each cycle
// against a queue-based behavioural model of the lane merge rules.
module tb_unstrip_lane_sched;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int MS = 8;
  localparam int IT = 4;

  logic         clk_2f = 1'b0;
  logic         reset_L = 1'b0;
  logic [W-1:0] lane_0 = '0;
  logic         valid_0 = 1'b0;
  logic [W-1:0] lane_1 = '0;
  logic         valid_1 = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out, next_lane, active, skew_err;

  unstrip_lane_sched #(.WIDTH(W), .DEPTH(D), .MAX_STALL(MS), .IDLE_TO(IT)) dut (
    .clk_2f(clk_2f), .reset_L(reset_L),
    .lane_0(lane_0), .valid_0(valid_0),
    .lane_1(lane_1), .valid_1(valid_1),
    .data_out(data_out), .valid_out(valid_out), .next_lane(next_lane),
    .active(active), .skew_err(skew_err)
  );

  always #5 clk_2f = ~clk_2f;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 sync, 2 run, 3 error
  int           m_mode = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           m_stall = 0;
  int           m_idle = 0;
  logic [W-1:0] m_data = '0;
  logic         m_valid = 1'b0;
  logic         m_next = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic pop_ok, ovf, idle_c, both;
    if (!reset_L) begin
      q0.delete(); q1.delete();
      m_mode = 0; m_stall = 0; m_idle = 0;
      m_data = '0; m_valid = 1'b0; m_next = 1'b0;
      return;
    end
    if (m_mode == 3) begin
      q0.delete(); q1.delete();
      m_mode = 0; m_stall = 0; m_idle = 0;
      m_valid = 1'b0; m_next = 1'b0;
      return;
    end
    pop_ok = (m_mode == 2) && (m_next ? (q1.size() > 0) : (q0.size() > 0));
    ovf    = (valid_0 && q0.size() == D && !(pop_ok && !m_next)) ||
             (valid_1 && q1.size() == D && !(pop_ok && m_next));
    idle_c = (q0.size() == 0) && (q1.size() == 0) && !valid_0 && !valid_1 && !m_next;
    both   = (q0.size() > 0) && (q1.size() > 0);
    if (pop_ok) begin
      if (m_next) m_data = q1.pop_front();
      else        m_data = q0.pop_front();
      m_valid = 1'b1;
      m_next  = !m_next;
    end else begin
      m_valid = 1'b0;
    end
    if (valid_0 && q0.size() < D) q0.push_back(lane_0);
    if (valid_1 && q1.size() < D) q1.push_back(lane_1);
    case (m_mode)
      0: if (valid_0 || valid_1) m_mode = 1;
      1: begin
        if (ovf) m_mode = 3;
        else if (both) begin m_mode = 2; m_stall = 0; end
        else begin
          m_stall++;
          if (m_stall >= MS) m_mode = 3;
        end
      end
      default: begin
        m_stall = pop_ok ? 0 : m_stall + 1;
        m_idle  = idle_c ? m_idle + 1 : 0;
        if (ovf || m_stall >= MS) m_mode = 3;
        else if (m_idle >= IT) m_mode = 0;
      end
    endcase
    if (m_mode != 2) m_idle = 0;
    if (m_mode == 0) m_stall = 0;
  endtask

  task automatic cycle(input logic rst_n, input logic v0, input logic v1);
    @(negedge clk_2f);
    reset_L = rst_n;
    valid_0 = v0;
    valid_1 = v1;
    lane_0  = $urandom;
    lane_1  = $urandom;
    model_step();
    @(posedge clk_2f);
    #1;
    check("data_out",  data_out,  m_data);
    check("valid_out", W'(valid_out), W'(m_valid));
    check("next_lane", W'(next_lane), W'(m_next));
    check("active",    W'(active),    W'(m_mode == 1 || m_mode == 2));
    check("skew_err",  W'(skew_err),  W'(m_mode == 3));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic fresh_start();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] hist;
  int         rmode;
  logic       rv0, rv1;

  initial begin
    fresh_start();

    // aligned burst, then clean idle exit
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1);
    idle_cycles(10);

    // lane 1 lags lane 0 by two cycles
    fresh_start();
    for (int i = 0; i < 6; i++) cycle(1'b1, i < 4, i >= 2);
    idle_cycles(12);

    // lane 1 dead
    fresh_start();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
    idle_cycles(6);

    // overflow of lane 0
    fresh_start();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
    idle_cycles(4);

    // odd word count ends in a stall error
    fresh_start();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, i < 2);
    idle_cycles(16);

    // reset in the middle of a running burst, then restart
    fresh_start();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1);
    idle_cycles(10);

    // randomized traffic in varying regimes
    hist = '0;
    rmode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 40 == 0) rmode = $urandom_range(0, 3);
      case (rmode)
        0: begin rv0 = ($urandom_range(0, 7) != 0); rv1 = rv0; end
        1: begin rv0 = $urandom_range(0, 1) == 1; rv1 = $urandom_range(0, 1) == 1; end
        2: begin rv0 = ($urandom_range(0, 3) != 0); rv1 = hist[1]; end
        default: begin rv0 = $urandom_range(0, 3) == 0; rv1 = $urandom_range(0, 3) == 0; end
      endcase
      hist = {hist[6:0], rv0};
      cycle(($urandom_range(0, 299) != 0), rv0, rv1);
    end
    idle_cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
